mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single MEM port between the cache (CPU) and a DMA
// requester, one transaction at a time, with a bus watchdog that converts a
// hung transaction into NXM.
//
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution.
// Without it, DMA wins every conflict (fixed priority).
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TOBITS  = 8,
  parameter int PADDR   = 18,
  parameter int WORD    = 36
) (
  input  logic             clk,
  input  logic             reset,
  // CPU (cache) side
  input  logic [PADDR-1:0] cpu_addr,
  input  logic [WORD-1:0]  cpu_write_data,
  input  logic             cpu_read,
  input  logic             cpu_write,
  output logic [WORD-1:0]  cpu_read_data,
  output logic             cpu_read_ack,
  output logic             cpu_write_ack,
  output logic             cpu_nxm,
  // DMA side
  input  logic [PADDR-1:0] dma_addr,
  input  logic [WORD-1:0]  dma_write_data,
  input  logic             dma_read,
  input  logic             dma_write,
  output logic [WORD-1:0]  dma_read_data,
  output logic             dma_read_ack,
  output logic             dma_write_ack,
  output logic             dma_nxm,
  // MEM side
  output logic [PADDR-1:0] mem_addr,
  output logic [WORD-1:0]  mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WORD-1:0]  mem_read_data,
  input  logic             mem_read_ack,
  input  logic             mem_write_ack,
  input  logic             mem_nxm,
  // current or most recent owner, 1 = DMA
  output logic             grant_dma
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } state_t;

  // Watchdog value seen during the TIMEOUT-th owned cycle (counter starts at 0).
  localparam logic [TOBITS-1:0] WD_LAST = TOBITS'(TIMEOUT - 1);
  localparam logic [TOBITS-1:0] WD_MAX  = {TOBITS{1'b1}};

  state_t            state_r;
  logic              grant_dma_r;
  logic [TOBITS-1:0] wd_r;

  logic cpu_pend_s;
  logic dma_pend_s;
  logic own_pend_s;
  logic timeout_s;
  logic resp_s;
  logic dma_wins_s;

  assign cpu_pend_s = cpu_read | cpu_write;
  assign dma_pend_s = dma_read | dma_write;
  assign resp_s     = mem_read_ack | mem_write_ack | mem_nxm;
  assign grant_dma  = grant_dma_r;

`ifdef MEM_ARB_RR_EN
  // Set once any grant has been made since reset; until then CPU wins a conflict.
  logic granted_once_r;

  // Track whether grant_dma reflects a real previous grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      granted_once_r <= 1'b0;
    end else if (state_r == IDLE && (cpu_pend_s || dma_pend_s)) begin
      granted_once_r <= 1'b1;
    end else begin
      granted_once_r <= granted_once_r;
    end
  end

  // Round robin: the side that did not own the previous grant wins.
  always_comb begin
    dma_wins_s = granted_once_r & ~grant_dma_r;
  end
`else
  // Fixed priority: DMA always wins a conflict.
  always_comb begin
    dma_wins_s = 1'b1;
  end
`endif

  // Owner strobe status and watchdog expiry for the current owned cycle.
  always_comb begin
    own_pend_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      OWN_CPU: begin
        own_pend_s = cpu_pend_s;
        timeout_s  = (wd_r >= WD_LAST);
      end
      OWN_DMA: begin
        own_pend_s = dma_pend_s;
        timeout_s  = (wd_r >= WD_LAST);
      end
      default: begin
        own_pend_s = 1'b0;
        timeout_s  = 1'b0;
      end
    endcase
  end

  // Ownership FSM, grant record and saturating watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      grant_dma_r <= 1'b0;
      wd_r        <= {TOBITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          wd_r <= {TOBITS{1'b0}};
          if (dma_pend_s && (!cpu_pend_s || dma_wins_s)) begin
            state_r     <= OWN_DMA;
            grant_dma_r <= 1'b1;
          end else if (cpu_pend_s) begin
            state_r     <= OWN_CPU;
            grant_dma_r <= 1'b0;
          end else begin
            state_r     <= IDLE;
            grant_dma_r <= grant_dma_r;
          end
        end
        OWN_CPU, OWN_DMA: begin
          grant_dma_r <= grant_dma_r;
          if (timeout_s || resp_s || !own_pend_s) begin
            // response, watchdog NXM or abort ends the transaction
            state_r <= IDLE;
            wd_r    <= wd_r;
          end else begin
            state_r <= state_r;
            if (wd_r != WD_MAX) begin
              wd_r <= wd_r + TOBITS'(1);
            end else begin
              wd_r <= wd_r;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          grant_dma_r <= grant_dma_r;
          wd_r        <= {TOBITS{1'b0}};
        end
      endcase
    end
  end

  // MEM port mux and response steering; everything quiet in IDLE and reset.
  always_comb begin
    mem_addr       = {PADDR{1'b0}};
    mem_write_data = {WORD{1'b0}};
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    cpu_read_data  = {WORD{1'b0}};
    cpu_read_ack   = 1'b0;
    cpu_write_ack  = 1'b0;
    cpu_nxm        = 1'b0;
    dma_read_data  = {WORD{1'b0}};
    dma_read_ack   = 1'b0;
    dma_write_ack  = 1'b0;
    dma_nxm        = 1'b0;
    case (state_r)
      OWN_CPU: begin
        mem_addr       = cpu_addr;
        mem_write_data = cpu_write_data;
        if (reset) begin
          cpu_nxm = 1'b0;
        end else if (timeout_s) begin
          // watchdog cycle: strobes withheld, NXM reported to the owner
          cpu_nxm = 1'b1;
        end else begin
          cpu_read_data = mem_read_data;
          mem_write     = cpu_write;
          mem_read      = cpu_read & ~cpu_write;
          cpu_read_ack  = mem_read_ack & cpu_pend_s;
          cpu_write_ack = mem_write_ack & cpu_pend_s;
          cpu_nxm       = mem_nxm & cpu_pend_s;
        end
      end
      OWN_DMA: begin
        mem_addr       = dma_addr;
        mem_write_data = dma_write_data;
        if (reset) begin
          dma_nxm = 1'b0;
        end else if (timeout_s) begin
          dma_nxm = 1'b1;
        end else begin
          dma_read_data = mem_read_data;
          mem_write     = dma_write;
          mem_read      = dma_read & ~dma_write;
          dma_read_ack  = mem_read_ack & dma_pend_s;
          dma_write_ack = mem_write_ack & dma_pend_s;
          dma_nxm       = mem_nxm & dma_pend_s;
        end
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

endmodule
